// File: rtl/fptd_section_sequencer_if.sv
// Frame-start handshake, razor error flags and phase/clear controls of fptd_section_sequencer.
// The bit_err_count signal exists only when FPTD_SEQ_STATS_EN is defined.
interface fptd_section_sequencer_if #(
    parameter int NSEC  = 4,
    parameter int CNT_W = 8
);
    logic             start_valid;
    logic             start_ready;
    logic             abort;
    logic [NSEC-1:0]  razor_err;
    logic [NSEC-1:0]  b1_error;
    logic             Enable;
    logic             nClear;
    logic             busy;
    logic             done;
    logic             fail;
    logic [CNT_W-1:0] step_count;
    logic [CNT_W-1:0] err_count;
`ifdef FPTD_SEQ_STATS_EN
    logic [CNT_W-1:0] bit_err_count;
`endif

    modport master (
        output start_valid, abort, razor_err, b1_error,
        input  start_ready, Enable, nClear, busy, done, fail, step_count, err_count
`ifdef FPTD_SEQ_STATS_EN
        , input bit_err_count
`endif
    );

    modport slave (
        input  start_valid, abort, razor_err, b1_error,
        output start_ready, Enable, nClear, busy, done, fail, step_count, err_count
`ifdef FPTD_SEQ_STATS_EN
        , output bit_err_count
`endif
    );
endinterface

// File: rtl/fptd_section_sequencer.sv
// Phase sequencer for pipelined FPTD sections: frame clear, even/odd phases, razor replay.
// Define FPTD_SEQ_STATS_EN to add the saturating hard-decision error accumulator bit_err_count.
module fptd_section_sequencer #(
    parameter int NSEC      = 4,
    parameter int STEPS     = 16,
    parameter int MAX_RETRY = 3,
    parameter int CNT_W     = 8
) (
    input  logic Clock,
    input  logic nReset,
    fptd_section_sequencer_if.slave bus
);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN_EVEN, RUN_ODD, REPLAY, DONE} state_t;

    state_t           state, next_state;
    logic             held_even;
    logic [RW-1:0]    retry;
    logic [CNT_W-1:0] step_count;
    logic [CNT_W-1:0] err_count;
    logic             fail;

    logic any_err, last_step;
    logic accept, step_inc, err_inc, retry_inc, retry_clr, fail_set, hold_load, hold_even_d;

    assign any_err   = |bus.razor_err;
    assign last_step = (step_count + 1'b1) == CNT_W'(STEPS);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= next_state;
    end

    // A replay either retries the held phase or, once out of retries, moves on as if it were clean.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        step_inc    = 1'b0;
        err_inc     = 1'b0;
        retry_inc   = 1'b0;
        retry_clr   = 1'b0;
        fail_set    = 1'b0;
        hold_load   = 1'b0;
        hold_even_d = held_even;
        case (state)
            IDLE: begin
                if (bus.start_valid) begin
                    accept     = 1'b1;
                    next_state = CLEAR;
                end
            end
            CLEAR: next_state = RUN_EVEN;
            RUN_EVEN: begin
                if (any_err) begin
                    err_inc     = 1'b1;
                    retry_inc   = 1'b1;
                    hold_load   = 1'b1;
                    hold_even_d = 1'b1;
                    next_state  = REPLAY;
                end else begin
                    next_state = RUN_ODD;
                end
            end
            RUN_ODD: begin
                if (any_err) begin
                    err_inc     = 1'b1;
                    retry_inc   = 1'b1;
                    hold_load   = 1'b1;
                    hold_even_d = 1'b0;
                    next_state  = REPLAY;
                end else begin
                    step_inc   = 1'b1;
                    next_state = last_step ? DONE : RUN_EVEN;
                end
            end
            REPLAY: begin
                if (any_err && retry != RW'(MAX_RETRY)) begin
                    err_inc   = 1'b1;
                    retry_inc = 1'b1;
                end else begin
                    err_inc   = any_err;
                    fail_set  = any_err;
                    retry_clr = 1'b1;
                    if (held_even) begin
                        next_state = RUN_ODD;
                    end else begin
                        step_inc   = 1'b1;
                        next_state = last_step ? DONE : RUN_EVEN;
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (bus.abort && state != IDLE) begin
            next_state = IDLE;
            step_inc   = 1'b0;
            err_inc    = 1'b0;
            retry_inc  = 1'b0;
            retry_clr  = 1'b0;
            fail_set   = 1'b0;
            hold_load  = 1'b0;
        end
    end

    always_comb begin
        bus.start_ready = 1'b0;
        bus.Enable      = 1'b0;
        bus.nClear      = 1'b1;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        case (state)
            IDLE:     bus.start_ready = 1'b1;
            CLEAR:    begin bus.nClear = 1'b0; bus.busy = 1'b1; end
            RUN_EVEN: begin bus.Enable = 1'b1; bus.busy = 1'b1; end
            RUN_ODD:  bus.busy = 1'b1;
            REPLAY:   begin bus.Enable = held_even; bus.busy = 1'b1; end
            DONE:     bus.done = 1'b1;
            default:  bus.start_ready = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            held_even  <= 1'b0;
            retry      <= '0;
            step_count <= '0;
            err_count  <= '0;
            fail       <= 1'b0;
        end else if (accept) begin
            retry      <= '0;
            step_count <= '0;
            err_count  <= '0;
            fail       <= 1'b0;
        end else begin
            if (hold_load) held_even <= hold_even_d;
            if (retry_clr)      retry <= '0;
            else if (retry_inc) retry <= retry + 1'b1;
            if (step_inc) step_count <= step_count + 1'b1;
            if (err_inc && err_count != '1) err_count <= err_count + 1'b1;
            if (fail_set) fail <= 1'b1;
        end
    end

    assign bus.step_count = step_count;
    assign bus.err_count  = err_count;
    assign bus.fail       = fail;

`ifdef FPTD_SEQ_STATS_EN
    logic [CNT_W-1:0] bit_err_count;
    logic [CNT_W:0]   pop, bit_sum;
    logic             stat_add;

    // Only first-attempt odd phases accumulate, so a replayed step never counts twice.
    assign stat_add = (state == RUN_ODD) && !any_err && !bus.abort;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < NSEC; i++) pop = pop + (CNT_W+1)'(bus.b1_error[i]);
        bit_sum = {1'b0, bit_err_count} + pop;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)       bit_err_count <= '0;
        else if (accept)   bit_err_count <= '0;
        else if (stat_add) bit_err_count <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    end

    assign bus.bit_err_count = bit_err_count;
`else
    logic b1_unused;
    assign b1_unused = ^bus.b1_error;
`endif
endmodule

// File: tb/tb_fptd_section_sequencer.sv
// Directed and randomized frames for fptd_section_sequencer, checked against a phase-index model.
// The model tracks the frame as a list of 2*STEPS phases and a per-phase attempt count.
module tb_fptd_section_sequencer;
    localparam int NSEC      = 4;
    localparam int STEPS     = 16;
    localparam int MAX_RETRY = 3;
    localparam int CNT_W     = 8;
    localparam int SAT       = (1 << CNT_W) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    logic Clock = 1'b0;
    logic nReset;
    always #5 Clock = ~Clock;

    fptd_section_sequencer_if #(.NSEC(NSEC), .CNT_W(CNT_W)) bus ();

    fptd_section_sequencer #(
        .NSEC(NSEC), .STEPS(STEPS), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
    ) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int m_mode, m_ph, m_retry, m_steps, m_errs, m_bits;
    bit m_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_ph = 0; m_retry = 0;
        m_steps = 0; m_errs = 0; m_bits = 0; m_fail = 0;
    endtask

    // Retries count failed attempts of the current phase; a nonzero count means this cycle is a replay.
    task automatic model_step(input logic sv, input logic ab, input logic [NSEC-1:0] re,
                              input logic [NSEC-1:0] b1);
        bit adv;
        if (m_mode == M_IDLE) begin
            if (sv) begin
                m_mode = M_CLEAR; m_ph = 0; m_retry = 0;
                m_steps = 0; m_errs = 0; m_bits = 0; m_fail = 0;
            end
        end else if (ab) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_CLEAR) begin
            m_mode = M_RUN;
        end else if (m_mode == M_DONE) begin
            m_mode = M_IDLE;
        end else begin
            adv = 1;
            if (re != 0) begin
                if (m_errs < SAT) m_errs++;
                if (m_retry == MAX_RETRY) begin
                    m_fail = 1; m_retry = 0;
                end else begin
                    m_retry++; adv = 0;
                end
            end else begin
                if (m_ph % 2 == 1 && m_retry == 0) m_bits = (m_bits + $countones(b1) > SAT) ? SAT : m_bits + $countones(b1);
                m_retry = 0;
            end
            if (adv) begin
                m_ph++;
                m_steps = m_ph / 2;
                if (m_ph == 2 * STEPS) m_mode = M_DONE;
            end
        end
    endtask

    task automatic check_outputs();
        chk("start_ready", 32'(bus.start_ready), 32'(m_mode == M_IDLE));
        chk("enable",      32'(bus.Enable),      32'(m_mode == M_RUN && m_ph % 2 == 0));
        chk("nclear",      32'(bus.nClear),      32'(m_mode != M_CLEAR));
        chk("busy",        32'(bus.busy),        32'(m_mode == M_CLEAR || m_mode == M_RUN));
        chk("done",        32'(bus.done),        32'(m_mode == M_DONE));
        chk("fail",        32'(bus.fail),        32'(m_fail));
        chk("step_count",  32'(bus.step_count),  32'(m_steps));
        chk("err_count",   32'(bus.err_count),   32'(m_errs));
`ifdef FPTD_SEQ_STATS_EN
        chk("bit_err_count", 32'(bus.bit_err_count), 32'(m_bits));
`endif
    endtask

    task automatic drive_cycle(input logic sv, input logic ab, input logic [NSEC-1:0] re,
                               input logic [NSEC-1:0] b1);
        bus.start_valid = sv;
        bus.abort       = ab;
        bus.razor_err   = re;
        bus.b1_error    = b1;
        @(posedge Clock);
        model_step(sv, ab, re, b1);
        @(negedge Clock);
        check_outputs();
    endtask

    // lat is the cycle (CLEAR = 1) in which done was observed, or -1 if the frame ended without done.
    task automatic run_frame(input int err_ph, input int err_len, input logic [NSEC-1:0] err_pat,
                             input int abort_ph, input bit ab_start, input bit rnd, output int lat);
        logic [NSEC-1:0] re, b1;
        logic            ab;
        bit              started = 0;
        int              left = 0;
        lat = -1;
        drive_cycle(1'b1, ab_start, '0, 4'b1011);
        for (int k = 1; k < 400; k++) begin
            re = '0;
            ab = 1'b0;
            b1 = rnd ? NSEC'($urandom) : 4'b1011;
            if (m_mode == M_RUN && m_ph == err_ph && m_retry == 0 && !started) begin
                started = 1; left = err_len;
            end
            if (left > 0) begin re = err_pat; left--; end
            if (rnd && $urandom_range(0, 7) == 0) re = NSEC'($urandom_range(1, 15));
            if (m_mode == M_RUN && m_ph == abort_ph && m_retry == 0) ab = 1'b1;
            if (rnd && $urandom_range(0, 149) == 0) ab = 1'b1;
            drive_cycle(1'b0, ab, re, b1);
            if (bus.done === 1'b1) lat = k + 1;
            if (m_mode == M_IDLE) break;
        end
        chk("frame_ends_idle", 32'(bus.start_ready), 32'd1);
    endtask

    int lat;

    initial begin
        nReset = 1'b0;
        bus.start_valid = 1'b0;
        bus.abort       = 1'b0;
        bus.razor_err   = '0;
        bus.b1_error    = '0;
        model_reset();
        @(negedge Clock);
        @(negedge Clock);
        check_outputs();
        chk("reset_nclear", 32'(bus.nClear), 32'd1);
        nReset = 1'b1;
        drive_cycle(1'b0, 1'b1, 4'b1111, '0);

        // Clean frame: done at cycle 34.
        run_frame(-1, 0, '0, -1, 1'b0, 1'b0, lat);
        chk("clean_latency", 32'(lat), 32'd34);
        chk("clean_steps", 32'(bus.step_count), 32'd16);
        chk("clean_errs", 32'(bus.err_count), 32'd0);
`ifdef FPTD_SEQ_STATS_EN
        chk("clean_bit_errs", 32'(bus.bit_err_count), 32'd48);
`endif
        drive_cycle(1'b0, 1'b0, '0, '0);
        chk("idle_holds_steps", 32'(bus.step_count), 32'd16);

        // One razor error on the odd phase of step 5 costs one cycle.
        run_frame(9, 1, 4'b0010, -1, 1'b0, 1'b0, lat);
        chk("odd_err_latency", 32'(lat), 32'd35);
        chk("odd_err_errs", 32'(bus.err_count), 32'd1);
        chk("odd_err_steps", 32'(bus.step_count), 32'd16);

        // Five error cycles from an even phase: retries exhaust, fail sticks, frame completes.
        run_frame(4, 5, 4'b0100, -1, 1'b0, 1'b0, lat);
        chk("retry_latency", 32'(lat), 32'd38);
        chk("retry_fail", 32'(bus.fail), 32'd1);
        chk("retry_errs", 32'(bus.err_count), 32'd5);

        // Error on the odd phase of the last step delays done.
        run_frame(31, 2, 4'b1000, -1, 1'b0, 1'b0, lat);
        chk("last_odd_latency", 32'(lat), 32'd36);
        chk("last_odd_steps", 32'(bus.step_count), 32'd16);

        // Abort during step 8.
        run_frame(-1, 0, '0, 15, 1'b0, 1'b0, lat);
        chk("abort_no_done", 32'(lat), 32'hffffffff);
        chk("abort_ready", 32'(bus.start_ready), 32'd1);
        chk("abort_enable", 32'(bus.Enable), 32'd0);
        chk("abort_steps", 32'(bus.step_count), 32'd7);

        // Start together with abort in IDLE is accepted.
        run_frame(-1, 0, '0, -1, 1'b1, 1'b0, lat);
        chk("abort_start_latency", 32'(lat), 32'd34);
        chk("abort_start_fail", 32'(bus.fail), 32'd0);

        // Asynchronous reset at step 3.
        drive_cycle(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 20 && m_ph != 5; k++) drive_cycle(1'b0, 1'b0, '0, '0);
        chk("pre_reset_steps", 32'(bus.step_count), 32'd2);
        #2 nReset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("async_reset_busy", 32'(bus.busy), 32'd0);
        @(posedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
        check_outputs();
        run_frame(-1, 0, '0, -1, 1'b0, 1'b0, lat);
        chk("post_reset_latency", 32'(lat), 32'd34);

        // Randomized frames with idle gaps.
        for (int f = 0; f < 12; f++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--)
                drive_cycle(1'b0, 1'($urandom), NSEC'($urandom), NSEC'($urandom));
            run_frame(-1, 0, '0, -1, 1'($urandom), 1'b1, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
